// File: rtl/mips_alu_unit.sv
// Multi-cycle MIPS ALU: logic/arithmetic ops finish in one execute cycle,
// shifts step one bit per cycle through a working register.
module mips_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [4:0]       shamt_r;
  logic [WIDTH-1:0] work;
  logic [4:0]       count;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] shifted;
  logic             is_shift;

  // SLT uses a true signed compare so it stays correct when a-b overflows
  always_comb begin
    sum      = a_r + b_r;
    diff     = a_r - b_r;
    alu_res  = '0;
    alu_ovf  = 1'b0;
    is_shift = (op_r[2:1] == 2'b11);
    shifted  = op_r[0] ? (work >> 1) : (work << 1);
    case (op_r)
      3'b000: alu_res = a_r & b_r;
      3'b001: alu_res = a_r | b_r;
      3'b010: begin
        alu_res = sum;
        alu_ovf = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      3'b011: begin
        alu_res = diff;
        alu_ovf = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff[WIDTH-1] != a_r[WIDTH-1]);
      end
      3'b100: alu_res = ($signed(a_r) < $signed(b_r)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      3'b101: alu_res = ~(a_r | b_r);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      shamt_r  <= '0;
      work     <= '0;
      count    <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r    <= alu_control;
            a_r     <= a;
            b_r     <= b;
            shamt_r <= shamt;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (!is_shift) begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            overflow <= alu_ovf;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (shamt_r == 5'd0) begin
            result   <= b_r;
            zero     <= (b_r == '0);
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            work  <= b_r;
            count <= shamt_r;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= shifted;
          count <= count - 5'd1;
          // Last step: the value shifted this cycle is the final result
          if (count == 5'd1) begin
            result   <= shifted;
            zero     <= (shifted == '0);
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Scoreboard bench for mips_alu_unit: the driver queues expected results,
// a monitor pops and checks them on every done pulse.
module tb_mips_alu_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  alu_control;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic        ov;
    int          st;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mips_alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .shamt(shamt), .result(result), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_result"}, result, e.res);
          checkOutput({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.z});
          checkOutput({e.name, "_overflow"}, {31'b0, overflow}, {31'b0, e.ov});
          checkOutput({e.name, "_latency"}, cyc - e.st, e.lat);
        end
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [2:0] op,
                               input logic [31:0] va, input logic [31:0] vb,
                               input logic [4:0] sa, input logic [31:0] er,
                               input logic ez, input logic eov, input int lat,
                               input bit stray, input bit no_wait);
    exp_t e;
    int   st;
    bit   seen;
    if (!no_wait) @(negedge clk);
    alu_control = op;
    a           = va;
    b           = vb;
    shamt       = sa;
    start       = 1'b1;
    st          = cyc;
    e.name = name; e.res = er; e.z = ez; e.ov = eov; e.st = st; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start       = 1'b0;
    a           = ~va;
    b           = va ^ vb ^ 32'h5a5a5a5a;
    shamt       = ~sa;
    alu_control = ~op;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        checkOutput({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      end else begin
        checkOutput({name, "_busy"}, {31'b0, busy}, 32'd1);
        start = stray && ((cyc - st) == 2 || (cyc - st) == 6);
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got no done expected done within 40 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    int st;
    rst = 1'b1; start = 1'b0; alu_control = '0; a = '0; b = '0; shamt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_zero", {31'b0, zero}, 32'd0);
    checkOutput("reset_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);

    applyStimulus("add_ovf",   3'b010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    applyStimulus("sub_zero",  3'b011, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("slt_neg",   3'b100, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("slt_wrap",  3'b100, 32'h80000000, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("slt_false", 3'b100, 32'h7FFFFFFF, 32'h80000000, 5'd0, 32'h00000000, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("and",       3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("or",        3'b001, 32'h12340000, 32'h00005678, 5'd0, 32'h12345678, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("nor_ones",  3'b101, 32'h00000000, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("nor_zero",  3'b101, 32'hFFFFFFFF, 32'h00000000, 5'd0, 32'h00000000, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("sub_ovf",   3'b011, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    applyStimulus("add_wrap",  3'b010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("add_ovf2",  3'b010, 32'h80000000, 32'h80000000, 5'd0, 32'h00000000, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    applyStimulus("sll_3",     3'b110, 32'h12345678, 32'h0000000F, 5'd3, 32'h00000078, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    applyStimulus("sll_31",    3'b110, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 33, 1'b0, 1'b0);
    applyStimulus("srl_0",     3'b111, 32'h00000000, 32'h80000000, 5'd0, 32'h80000000, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus("srl_4",     3'b111, 32'h00000000, 32'hF0000000, 5'd4, 32'h0F000000, 1'b0, 1'b0, 6, 1'b0, 1'b0);
    applyStimulus("srl_10",    3'b111, 32'h00000000, 32'hFFFFFFFF, 5'd10, 32'h003FFFFF, 1'b0, 1'b0, 12, 1'b1, 1'b0);
    applyStimulus("add_pre",   3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b1, 2, 1'b0, 1'b0);

    // Abort a long shift with reset; no done may follow
    @(negedge clk);
    alu_control = 3'b110; a = '0; b = 32'h1; shamt = 5'd20; start = 1'b1; st = cyc;
    @(negedge clk);
    start = 1'b0;
    while ((cyc - st) < 5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_result", result, 32'd0);
    checkOutput("rst_mid_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("rst_mid_zero", {31'b0, zero}, 32'd0);
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus("and_after_rst", 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0, 2, 1'b0, 1'b1);

    repeat (30) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_alu_unit.md
MIPS_ALU_UNIT -- requirements
Module: mips_alu_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, the operand and result width in bits; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a one-cycle request that launches an operation.
REQ-005 The block SHALL have port alu_control, input, 3 bits, the operation select produced by mips_alu_control.
REQ-006 The block SHALL have ports a and b, each input, WIDTH bits: operand A, and operand B or the shift source.
REQ-007 The block SHALL have port shamt, input, 5 bits, the shift amount.
REQ-008 The block SHALL have port result, output, WIDTH bits, the registered result.
REQ-009 The block SHALL have port zero, output, 1 bit, registered, high when result equals 0.
REQ-010 The block SHALL have port overflow, output, 1 bit, the registered signed overflow for ADD and SUB.
REQ-011 The block SHALL have port busy, output, 1 bit, high while an operation is in flight.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the cycle result is valid.

Function
REQ-013 alu_control encoding SHALL be:
- 000 AND
- 001 OR
- 010 ADD
- 011 SUB
- 100 SLT (signed)
- 101 NOR
- 110 SLL
- 111 SRL
REQ-014 The FSM SHALL have states IDLE, EXEC, SHIFT and DONE; reset state IDLE.
REQ-015 In IDLE, start=1 SHALL latch a, b, shamt and alu_control into internal registers, assert busy and go to EXEC.
REQ-016 In IDLE, start=0 SHALL leave all outputs unchanged and remain in IDLE.
REQ-017 In EXEC, non-shift ops (AND, OR, ADD, SUB, SLT, NOR) SHALL compute from the latched operands, register result, zero and overflow, and go to DONE.
REQ-018 In EXEC, a shift op with latched shamt=0 SHALL register result=b and go to DONE.
REQ-019 In EXEC, a shift op with shamt>0 SHALL load a working register with b, load a 5-bit counter with shamt, and go to SHIFT.
REQ-020 In SHIFT, each cycle SHALL shift the working register by exactly one bit (SLL left, SRL logical right, zero fill) and decrement the counter.
REQ-021 When the counter reaches 0, the working value SHALL go to result and the FSM SHALL go to DONE.
REQ-022 In DONE, done SHALL be 1 and busy SHALL be 0 for exactly one cycle, then the FSM returns to IDLE.
REQ-023 Latency from the start cycle to the done cycle SHALL be 2 cycles for non-shift ops and for shamt=0, and shamt+2 cycles for shifts with shamt>0 (maximum 33).
REQ-024 ADD and SUB SHALL wrap modulo 2^32.
REQ-025 overflow SHALL be 1 when the operands have matching sign and the result sign differs; for SUB, B's sign is inverted first.
REQ-026 overflow SHALL be 0 for every op other than ADD and SUB.
REQ-027 SLT SHALL return 32'h1 if signed a < signed b, else 0, and SHALL be correct when a-b overflows.
REQ-028 start asserted while busy=1, or in DONE, SHALL be ignored; no queuing, latched operands unchanged.
REQ-029 Input changes after the start cycle SHALL NOT affect the in-flight result.
REQ-030 result, zero and overflow SHALL hold their value from done until the next operation's done.
REQ-031 zero SHALL be derived from the value being written into result, in the same cycle.

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, result=0, zero=0, overflow=0, busy=0, done=0, counter=0.
REQ-033 Reset asserted mid-operation (EXEC, SHIFT or DONE) SHALL abort the operation with no done pulse.
REQ-034 After rst deasserts, the first start SHALL be accepted on the first rising clk edge.

Verification
REQ-035 ADD, a=32'h7FFFFFFF, b=1 -> 2 cycles later done=1, result=32'h80000000, overflow=1, zero=0.
REQ-036 SUB, a=5, b=5 -> result=0, zero=1, overflow=0; SLT, a=32'hFFFFFFFF, b=1 -> result=1.
REQ-037 SLL, b=32'h1, shamt=31 -> done exactly 33 cycles after start, result=32'h80000000; busy is 1 for cycles 1-32.
REQ-038 SRL, b=32'h80000000, shamt=0 -> done at cycle 2, result=32'h80000000.
REQ-039 Second start pulses during a SRL shamt=10 run -> ignored; a single done at cycle 12 with the first operation's result.
REQ-040 rst asserted in SHIFT with shamt=20 at cycle 5 -> outputs zero immediately, no done pulse; a new AND, a=32'hF0F0F0F0, b=32'hFF00FF00 -> result=32'hF000F000.
